// File: rtl/or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : or1200_vlx_packer
//  Purpose  : Variable-length code packer for JPEG entropy coding. Codes of
//             up to MAX_BITS bits are shifted MSB-first into an accumulator.
//             Whole bytes are moved into a small byte FIFO, with an optional
//             0x00 inserted after every 0xFF. The FIFO is drained one byte at
//             a time through the store-unit handshake. A flush pads the final
//             partial byte with ones and waits until every byte has been
//             stored.
//  Ports    : clk_i, rst_i             clock, synchronous active-high reset
//             set_bit_op_i, num_bits_i, dat_i
//                                      set-bit instruction and its operands
//             spr_cs, spr_write, spr_addr, spr_dat_i, spr_dat_o
//                                      control/status register access
//             ack_i, store_byte_o, vlx_addr_o, dat_o
//                                      byte store handshake
//             stall_cpu_o              CPU stall
//  Revision : 1.0  initial release
// ============================================================================
module or1200_vlx_packer #(
    parameter int          MAX_BITS   = 16,
    parameter int          ACC_W      = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_RST   = 32'h0383c1d0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_bit_op_i,
    input  logic [4:0]          num_bits_i,
    input  logic [MAX_BITS-1:0] dat_i,
    input  logic                spr_cs,
    input  logic                spr_write,
    input  logic [1:0]          spr_addr,
    input  logic [31:0]         spr_dat_i,
    output logic [31:0]         spr_dat_o,
    input  logic                ack_i,
    output logic                store_byte_o,
    output logic [31:0]         vlx_addr_o,
    output logic [31:0]         dat_o,
    output logic                stall_cpu_o
);

    localparam int CW = $clog2(ACC_W + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_pad   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [1:0]       r_state;
    logic             r_stuff_en;
    logic [31:0]      r_addr;
    logic [31:0]      r_byte_cnt;

    logic [4:0]       w_n;
    logic [31:0]      w_sum;
    logic             w_accept;
    logic [ACC_W-1:0] w_code;
    logic             w_have_byte;
    logic [7:0]       w_top;
    logic             w_stuff;
    logic [LW-1:0]    w_free;
    logic             w_extract;
    logic [LW-1:0]    w_push_n;
    logic             w_pop;
    logic             w_pad;
    logic [3:0]       w_pad_n;
    logic [ACC_W-1:0] w_pad_ones;
    logic             w_spr_wr;
    logic             w_busy;

    always_comb begin
        // Over-long lengths are clamped rather than rejected.
        w_n         = (num_bits_i > 5'(MAX_BITS)) ? 5'(MAX_BITS) : num_bits_i;
        // Fit test uses the count before this cycle's extraction.
        w_sum       = 32'(r_cnt) + 32'(w_n);
        w_accept    = set_bit_op_i && (r_state == c_idle) && (w_sum <= 32'(ACC_W));
        // Bits of dat_i above the code length are discarded.
        w_code      = ACC_W'(dat_i) & ~({ACC_W{1'b1}} << w_n);
        w_have_byte = (r_cnt >= CW'(8));
        // Oldest eight valid bits sit just below the count.
        w_top       = 8'(r_acc >> (r_cnt - CW'(8)));
        w_stuff     = r_stuff_en && (w_top == 8'hFF);
        w_free      = LW'(FIFO_DEPTH) - r_level;
        // A stuffed 0xFF needs room for both bytes in the same cycle.
        w_extract   = w_have_byte && (w_stuff ? (w_free >= LW'(2)) : (w_free != '0));
        w_push_n    = w_extract ? (w_stuff ? LW'(2) : LW'(1)) : '0;
        w_pop       = ack_i && (r_level != '0);
        w_pad       = (r_state == c_pad) && !w_have_byte;
        w_pad_n     = 4'd8 - 4'(r_cnt);
        w_pad_ones  = ~({ACC_W{1'b1}} << w_pad_n);
        w_spr_wr    = spr_cs && spr_write;
        w_busy      = (r_state != c_idle) || (r_level != '0) || (r_cnt != '0);
    end

    // Accumulator: insert and extract may coincide; pad only happens once
    // fewer than eight bits remain, so it never overlaps an extraction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= (r_acc << w_n) | w_code;
            r_cnt <= r_cnt + CW'(w_n) - (w_extract ? CW'(8) : CW'(0));
        end else if (w_pad && (r_cnt != '0)) begin
            r_acc <= (r_acc << w_pad_n) | w_pad_ones;
            r_cnt <= CW'(8);
        end else if (w_extract) begin
            r_cnt <= r_cnt - CW'(8);
        end
    end

    // Byte storage carries no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_extract) begin
            r_mem[r_wr_ptr] <= w_top;
            if (w_stuff) begin
                r_mem[r_wr_ptr + PW'(1)] <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_extract) begin
                r_wr_ptr <= r_wr_ptr + (w_stuff ? PW'(2) : PW'(1));
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= r_level + w_push_n - LW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_idle;
        end else begin
            case (r_state)
                c_idle:  if (w_spr_wr && (spr_addr == 2'd0) && spr_dat_i[1]) r_state <= c_pad;
                c_pad:   if (!w_have_byte) r_state <= c_drain;
                c_drain: if ((r_cnt == '0) && (r_level == '0)) r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    // Software writes win over the ack-driven increments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stuff_en <= 1'b1;
            r_addr     <= ADDR_RST;
            r_byte_cnt <= '0;
        end else begin
            if (w_spr_wr && (spr_addr == 2'd0)) begin
                r_stuff_en <= spr_dat_i[0];
            end
            if (w_spr_wr && (spr_addr == 2'd1)) begin
                r_byte_cnt <= '0;
            end else if (w_pop) begin
                r_byte_cnt <= r_byte_cnt + 32'd1;
            end
            if (w_spr_wr && spr_addr[1]) begin
                r_addr <= spr_dat_i;
            end else if (w_pop) begin
                r_addr <= r_addr + 32'd1;
            end
        end
    end

    always_comb begin
        case (spr_addr)
            2'd0:    spr_dat_o = {16'b0, 8'(r_level), w_busy, 1'b0, 6'(r_cnt)};
            2'd1:    spr_dat_o = r_byte_cnt;
            default: spr_dat_o = r_addr;
        endcase
    end

    assign store_byte_o = (r_level != '0);
    assign dat_o        = store_byte_o ? {24'b0, r_mem[r_rd_ptr]} : 32'b0;
    assign vlx_addr_o   = r_addr;
    assign stall_cpu_o  = (set_bit_op_i && !w_accept) || (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_or1200_vlx_packer
//  Purpose  : Directed bench for or1200_vlx_packer. A bit-queue / byte-queue
//             model predicts every output each cycle; literal expectations
//             pin the stored byte stream for each scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_or1200_vlx_packer;

    localparam logic [31:0] ADDR_RST = 32'h0383c1d0;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        set_bit_op_i = 1'b0;
    logic [4:0]  num_bits_i = '0;
    logic [15:0] dat_i = '0;
    logic        spr_cs = 1'b0;
    logic        spr_write = 1'b0;
    logic [1:0]  spr_addr = '0;
    logic [31:0] spr_dat_i = '0;
    logic [31:0] spr_dat_o;
    logic        ack_i = 1'b0;
    logic        store_byte_o;
    logic [31:0] vlx_addr_o;
    logic [31:0] dat_o;
    logic        stall_cpu_o;

    or1200_vlx_packer #(
        .MAX_BITS(16), .ACC_W(32), .FIFO_DEPTH(4), .ADDR_RST(ADDR_RST)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .set_bit_op_i(set_bit_op_i),
        .num_bits_i(num_bits_i), .dat_i(dat_i), .spr_cs(spr_cs),
        .spr_write(spr_write), .spr_addr(spr_addr), .spr_dat_i(spr_dat_i),
        .spr_dat_o(spr_dat_o), .ack_i(ack_i), .store_byte_o(store_byte_o),
        .vlx_addr_o(vlx_addr_o), .dat_o(dat_o), .stall_cpu_o(stall_cpu_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=progress", nm);
    endtask

    // ---------------- behavioural model ----------------
    bit          mq[$];      // pending code bits, oldest (MSB) first
    logic [7:0]  fq[$];      // bytes waiting to be stored
    logic [31:0] m_addr;
    logic [31:0] m_bcnt;
    bit          m_stuff;
    int          m_st;       // 0 idle, 1 pad, 2 drain
    bit          chk_en = 0;

    function automatic int eff_n();
        return (int'(num_bits_i) > 16) ? 16 : int'(num_bits_i);
    endfunction

    function automatic bit m_accept();
        return set_bit_op_i && (m_st == 0) && (mq.size() + eff_n() <= 32);
    endfunction

    function automatic logic [7:0] m_top();
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t = {t[6:0], logic'(mq[i])};
        return t;
    endfunction

    function automatic logic [31:0] m_spr(input logic [1:0] a);
        logic busy;
        busy = (m_st != 0) || (fq.size() != 0) || (mq.size() != 0);
        if (a == 2'd0) return {16'b0, 8'(fq.size()), busy, 1'b0, 6'(mq.size())};
        if (a == 2'd1) return m_bcnt;
        return m_addr;
    endfunction

    always @(posedge clk) begin
        int qs;
        int fs;
        int st0;
        int n;
        bit acc;
        bit ext;
        bit stf;
        logic [7:0] tb;
        if (rst_i) begin
            mq.delete();
            fq.delete();
            m_addr  = ADDR_RST;
            m_bcnt  = 0;
            m_stuff = 1;
            m_st    = 0;
            chk_en  = 1;
        end else begin
            qs  = mq.size();
            fs  = fq.size();
            st0 = m_st;
            n   = eff_n();
            acc = m_accept();
            ext = 0;
            stf = 0;
            tb  = '0;
            if (qs >= 8) begin
                tb  = m_top();
                stf = m_stuff && (tb == 8'hFF);
                ext = ((4 - fs) >= (stf ? 2 : 1));
            end
            if (ack_i && fs > 0) begin
                void'(fq.pop_front());
                m_addr = m_addr + 1;
                m_bcnt = m_bcnt + 1;
            end
            if (ext) begin
                repeat (8) void'(mq.pop_front());
                fq.push_back(tb);
                if (stf) fq.push_back(8'h00);
            end
            if (acc) for (int i = n - 1; i >= 0; i--) mq.push_back(dat_i[i]);
            if (st0 == 1 && qs < 8) begin
                if (qs > 0) repeat (8 - qs) mq.push_back(1'b1);
                m_st = 2;
            end
            if (st0 == 2 && qs == 0 && fs == 0) m_st = 0;
            if (spr_cs && spr_write) begin
                if (spr_addr == 2'd0) begin
                    m_stuff = spr_dat_i[0];
                    if (spr_dat_i[1] && st0 == 0) m_st = 1;
                end
                if (spr_addr == 2'd1) m_bcnt = 0;
                if (spr_addr[1]) m_addr = spr_dat_i;
            end
        end
    end

    // ---------------- per-cycle compare + store log ----------------
    logic [7:0]  log_b[$];
    logic [31:0] log_a[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("store_byte_o", 32'(store_byte_o), 32'(fq.size() != 0));
            chk("dat_o", dat_o, (fq.size() != 0) ? {24'b0, fq[0]} : 32'b0);
            chk("vlx_addr_o", vlx_addr_o, m_addr);
            chk("stall_cpu_o", 32'(stall_cpu_o), 32'((set_bit_op_i && !m_accept()) || m_st != 0));
            chk("spr_dat_o", spr_dat_o, m_spr(spr_addr));
            if (ack_i && store_byte_o && !rst_i) begin
                log_b.push_back(dat_o[7:0]);
                log_a.push_back(vlx_addr_o);
            end
        end
    end

    // ---------------- store-unit responder ----------------
    bit ack_en = 1;
    bit prev_store = 0;
    always @(posedge clk) begin
        #1;
        ack_i = (ack_en && store_byte_o && prev_store && !ack_i && !rst_i);
        prev_store = store_byte_o;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spr_wr(input logic [1:0] a, input logic [31:0] d);
        spr_cs = 1; spr_write = 1; spr_addr = a; spr_dat_i = d;
        tick();
        spr_cs = 0; spr_write = 0; spr_addr = 2'd0; spr_dat_i = '0;
    endtask

    task automatic setbit(input int n, input logic [15:0] d, input int max_wait, output bit timed_out);
        set_bit_op_i = 1; num_bits_i = 5'(n); dat_i = d; timed_out = 0;
        for (int w = 0; ; w++) begin
            #1;
            if (!stall_cpu_o) begin
                @(posedge clk);
                #1;
                set_bit_op_i = 0;
                return;
            end
            if (w >= max_wait) begin
                timed_out = 1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb(input int n, input logic [15:0] d);
        bit to;
        setbit(n, d, 200, to);
        if (to) begin
            set_bit_op_i = 0;
            fail("setbit_accept");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (mq.size() == 0 && fq.size() == 0 && m_st == 0) begin
                tick();
                return;
            end
            tick();
        end
        fail("wait_idle");
    endtask

    task automatic check_log(input string nm, input int idx, input logic [7:0] b, input logic [31:0] a);
        if (idx < log_b.size()) begin
            chk({nm, "_byte"}, 32'(log_b[idx]), 32'(b));
            chk({nm, "_addr"}, log_a[idx], a);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s actual=missing required=%h@%h", nm, b, a);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bit to;
        int stall_idx;

        rst_i = 1; tick(); tick(); rst_i = 0;
        chk("reset_store", 32'(store_byte_o), 32'd0);
        chk("reset_addr", vlx_addr_o, 32'h0383c1d0);
        chk("reset_spr0", spr_dat_o, 32'd0);
        chk("reset_stall", 32'(stall_cpu_o), 32'd0);

        // Two codes form one byte: 101 + 11110 -> 0xBE
        spr_wr(2'd2, 32'h100);
        log_b.delete(); log_a.delete();
        sb(3, 16'h0005);
        sb(5, 16'h001E);
        wait_idle();
        chk("two_codes_count", 32'(log_b.size()), 32'd1);
        check_log("two_codes", 0, 8'hBE, 32'h100);
        chk("two_codes_addr", vlx_addr_o, 32'h101);
        spr_addr = 2'd1; #1;
        chk("two_codes_bytecnt", spr_dat_o, 32'd1);
        spr_addr = 2'd0;

        // Stuffing on: 0xFF followed by 0x00
        spr_wr(2'd2, 32'h100);
        log_b.delete(); log_a.delete();
        sb(8, 16'h00FF);
        wait_idle();
        chk("stuff_on_count", 32'(log_b.size()), 32'd2);
        check_log("stuff_on0", 0, 8'hFF, 32'h100);
        check_log("stuff_on1", 1, 8'h00, 32'h101);
        chk("stuff_on_addr", vlx_addr_o, 32'h102);

        // Zero-length no-op and over-long code clamped to 16 bits
        log_b.delete(); log_a.delete();
        sb(0, 16'h1234);
        sb(20, 16'hABCD);
        wait_idle();
        chk("clamp_count", 32'(log_b.size()), 32'd2);
        check_log("clamp0", 0, 8'hAB, 32'h102);
        check_log("clamp1", 1, 8'hCD, 32'h103);

        // Stuffing off: single 0xFF
        spr_wr(2'd0, 32'h0);
        log_b.delete(); log_a.delete();
        sb(8, 16'h00FF);
        wait_idle();
        chk("stuff_off_count", 32'(log_b.size()), 32'd1);
        check_log("stuff_off", 0, 8'hFF, 32'h104);
        spr_wr(2'd0, 32'h1);

        // Masking then flush: 1111 + 0 + pad 111 -> 0xF7
        log_b.delete(); log_a.delete();
        sb(4, 16'hFFFF);
        sb(1, 16'h0000);
        tick(); tick(); tick();
        chk("mask_nothing_stored", 32'(log_b.size()), 32'd0);
        chk("mask_spr0", spr_dat_o, 32'h0000_0085);
        spr_wr(2'd0, 32'h3);
        chk("flush_stall", 32'(stall_cpu_o), 32'd1);
        wait_idle();
        chk("flush_count", 32'(log_b.size()), 32'd1);
        check_log("flush", 0, 8'hF7, 32'h105);
        chk("flush_stall_release", 32'(stall_cpu_o), 32'd0);

        // Backpressure: eight codes fit (4 in FIFO, 32 bits in acc), ninth stalls
        spr_wr(2'd2, 32'h200);
        log_b.delete(); log_a.delete();
        ack_en = 0;
        stall_idx = -1;
        for (int k = 0; k < 10; k++) begin
            setbit(8, 16'h0012, 12, to);
            if (to) begin
                if (stall_idx < 0) stall_idx = k;
                chk("bp_stall", 32'(stall_cpu_o), 32'd1);
                chk("bp_spr0", spr_dat_o, 32'h0000_04A0);
                ack_en = 1;
                setbit(8, 16'h0012, 200, to);
                if (to) begin
                    set_bit_op_i = 0;
                    fail("bp_resume");
                end
            end
        end
        ack_en = 1;
        wait_idle();
        chk("bp_stall_index", 32'(stall_idx), 32'd8);
        chk("bp_count", 32'(log_b.size()), 32'd10);
        for (int i = 0; i < 10; i++) check_log("bp", i, 8'h12, 32'h200 + 32'(i));

        // Reset while a store is pending
        ack_en = 0;
        sb(8, 16'h0034);
        for (int i = 0; i < 20 && !store_byte_o; i++) tick();
        chk("rst_mid_pending", 32'(store_byte_o), 32'd1);
        rst_i = 1; tick(); rst_i = 0;
        chk("rst_mid_store", 32'(store_byte_o), 32'd0);
        chk("rst_mid_stall", 32'(stall_cpu_o), 32'd0);
        chk("rst_mid_addr", vlx_addr_o, ADDR_RST);
        chk("rst_mid_spr0", spr_dat_o, 32'd0);
        ack_en = 1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or1200_vlx_packer.md
Name: or1200_vlx_packer

Overview:
- Parametrised successor to the OR1200 VLX set-bit unit, used by the JPEG entropy-coding software.
- Packs variable-length codes of up to MAX_BITS bits, MSB-first, into an accumulator and extracts bytes into a byte FIFO.
- Optionally inserts a 0x00 after every 0xFF, and writes bytes one at a time through the store-unit handshake.
- Adds masking of unused input bits, buffered stores, JPEG pad-with-ones flush, and an SPR-controlled stuffing enable and byte counter.

Parameters:
- MAX_BITS, 16, maximum code length per set-bit operation (1..24).
- ACC_W, 32, accumulator width in bits; must be >= MAX_BITS+8.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.
- ADDR_RST, 32'h0383c1d0, reset value of the store address register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- set_bit_op_i  in  1  set-bit instruction valid.
- num_bits_i  in  5  code length, 0..MAX_BITS.
- dat_i  in  MAX_BITS  code bits, right-aligned.
- spr_cs  in  1  SPR chip select.
- spr_write  in  1  SPR write strobe.
- spr_addr  in  2  SPR register select.
- spr_dat_i  in  32  SPR write data.
- spr_dat_o  out  32  SPR read data.
- ack_i  in  1  store-unit acknowledge for the current byte.
- store_byte_o  out  1  byte store request.
- vlx_addr_o  out  32  store address.
- dat_o  out  32  {24'b0, byte}.
- stall_cpu_o  out  1  CPU stall.

Behaviour:
- Reset values:
  - All outputs 0 except vlx_addr_o = ADDR_RST.
  - Accumulator count cnt = 0, FIFO empty, byte counter = 0, stuff_en = 1, flush FSM = IDLE.
  - Reset mid-store drops the FIFO contents and the accumulator.
- Insert:
  - A set-bit operation is accepted when set_bit_op_i=1, FSM=IDLE and cnt+num_bits_i <= ACC_W, with cnt taken before this cycle's extract.
  - On accept: acc <= (acc << n) | (dat_i & ((1<<n)-1)); cnt += n.
  - n=0 is accepted as a no-op.
  - n > MAX_BITS is treated as MAX_BITS.
- Extract (same cycle as insert is allowed):
  - Condition: cnt >= 8 and the FIFO has room — 2 free slots if the top byte is 0xFF and stuff_en=1, otherwise 1.
  - The top byte acc[cnt-1 -: 8] is pushed and cnt -= 8.
  - When stuffing applies, 0xFF and then 0x00 are pushed in the same cycle.
  - Net count update: cnt_next = cnt + accepted_n - 8*extracted.
- Store handshake:
  - store_byte_o = FIFO non-empty. dat_o and vlx_addr_o show the FIFO head and stay stable until ack_i.
  - ack_i with store_byte_o=1: pop the head, vlx_addr_o += 1 (32-bit wrap), byte counter += 1.
  - ack_i with store_byte_o=0 is ignored.
  - Push and pop in the same cycle are legal.
- Stall:
  - Combinational: stall_cpu_o = (set_bit_op_i & ~accept) | (FSM != IDLE).
  - The instruction holds set_bit_op_i and its operands while stalled.
- Flush FSM: IDLE -> PAD -> DRAIN -> IDLE.
  - IDLE -> PAD on an SPR write to addr 0 with bit1=1.
  - PAD: wait until cnt < 8. Then, if cnt != 0, append (8-cnt) one-bits; cnt becomes 8. Go to DRAIN.
  - DRAIN: wait until cnt==0 and the FIFO is empty (last ack received), then go to IDLE.
  - Pad bytes are stuffed like any other byte.
- SPR map:
  - addr 0 write: bit0 = stuff_en, bit1 = flush request (self-clearing).
  - addr 0 read: {16'b0, fifo_level[7:0], busy, 1'b0, cnt[5:0]}, where busy = FSM!=IDLE | FIFO non-empty | cnt!=0.
  - addr 1 read: byte counter. addr 1 write: clears the byte counter.
  - addr 2/3 write: load the address register. This takes effect for the current head byte and wins over an ack increment in the same cycle.
  - addr 2/3 read: vlx_addr_o.
  - spr_dat_o is combinational on spr_addr.

Test Plan:
- Two codes into 0x100:
  - Stimulus: SPR addr2=0x100; set-bit 3'b101 n=3, then 5'b11110 n=5; ack 1 cycle after each request.
  - Required: one store of 0xBE at 0x100; vlx_addr_o=0x101; byte counter=1.
- Stuffing on:
  - Stimulus: n=8 dat=0xFF.
  - Required: stores 0xFF@0x100 then 0x00@0x101; vlx_addr_o ends at 0x102.
- Stuffing off:
  - Stimulus: stuff_en=0, same input.
  - Required: a single 0xFF store.
- Masking and flush:
  - Stimulus: n=4 dat=0xFFFF, then n=1 dat=0.
  - Required: nothing stored.
  - Stimulus: then flush.
  - Required: store 0xF7; stall_cpu_o stays high until that ack, then IDLE.
- Backpressure:
  - Stimulus: ack_i held low; ten n=8 codes of 0x12.
  - Required: FIFO fills to 4 and accumulator to 32 bits. stall_cpu_o asserts on the code that does not fit; it releases after acks resume. Bytes arrive in order with consecutive addresses.
- Reset mid-operation:
  - Stimulus: assert rst_i while store_byte_o=1.
  - Required: next cycle store_byte_o=0, stall_cpu_o=0, vlx_addr_o=ADDR_RST, SPR addr0 read = 0.
